// File: rtl/ethz_cpa_seq_if.sv
// rtl/ethz_cpa_seq_if.sv - operand/result handshake bundle for the sequential carry-propagate adder
interface ethz_cpa_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] c_i;
  logic [WIDTH-1:0] s_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;

  modport slave (
    input  c_i, s_i, valid_i, ready_i,
    output ready_o, sum_o, cout_o, valid_o, busy_o
  );

  modport master (
    output c_i, s_i, valid_i, ready_i,
    input  ready_o, sum_o, cout_o, valid_o, busy_o
  );
endinterface

// File: rtl/ethz_cpa_seq.sv
// rtl/ethz_cpa_seq.sv - resolves a carry-save pair into a binary sum, one CHUNK-bit slice per cycle
module ethz_cpa_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ethz_cpa_seq_if.slave bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SHW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("ethz_cpa_seq: CHUNK must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [SHW-1:0]   shamt;
  logic [CHUNK:0]   slice_sum;

  // Bit offset of the slice being resolved this cycle.
  assign shamt     = SHW'(idx_q * CHUNK);
  assign slice_sum = {1'b0, c_q[shamt +: CHUNK]} + {1'b0, s_q[shamt +: CHUNK]}
                   + (CHUNK+1)'(cy_q);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    s_d     = s_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          c_d     = bus.c_i;
          s_d     = bus.s_i;
          cy_d    = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[shamt +: CHUNK] = slice_sum[CHUNK-1:0];
        cy_d                  = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_sum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.sum_o   = sum_q;
  assign bus.cout_o  = cout_q;
endmodule
